// File: rtl/pipe_gap_gen.sv
// Turns a captured LFSR word into the next pipe gap row: 16-step restoring
// division for the modulo, then a clamp against the previous accepted gap.
module pipe_gap_gen #(
  parameter int Y_W      = 10,
  parameter int GAP_MIN  = 80,
  parameter int GAP_MAX  = 360,
  parameter int MAX_STEP = 120
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [31:0]    rnd,
  input  logic           req,
  input  logic           ack,
  output logic [Y_W-1:0] gap_y,
  output logic           valid,
  output logic           busy
);

  localparam int SW = Y_W + 3;
  localparam logic [Y_W+1:0]        RANGE_W = (Y_W+2)'(GAP_MAX - GAP_MIN + 1);
  localparam logic [Y_W-1:0]        MID     = Y_W'((GAP_MIN + GAP_MAX) / 2);
  localparam logic signed [SW-1:0]  GMIN_S  = SW'(GAP_MIN);
  localparam logic signed [SW-1:0]  GMAX_S  = SW'(GAP_MAX);
  localparam logic signed [SW-1:0]  STEP_S  = SW'(MAX_STEP);

  typedef enum logic [1:0] {IDLE, DIV, CLAMP, HOLD} state_t;

  state_t         state_q;
  logic [15:0]    sr_q;
  logic [Y_W:0]   rem_q;
  logic [3:0]     cnt_q;
  logic [Y_W-1:0] gapY_q;
  logic [Y_W-1:0] prev_q;
  logic           valid_q;
  logic           busy_q;

  logic [Y_W+1:0]       trial;
  logic [Y_W:0]         rem_d;
  logic                 unusedRemTop;
  logic signed [SW-1:0] candS, prevS, loS, hiS, clampS;
  logic [Y_W-1:0]       gapY_d;
  logic [2:0]           unusedClampTop;
  logic [15:0]          unusedRndHi;

  assign unusedRndHi = rnd[31:16];

  // One restoring-division step; the remainder always stays below RANGE.
  always_comb begin
    trial = {rem_q, sr_q[15]};
    {unusedRemTop, rem_d} = (trial >= RANGE_W) ? (trial - RANGE_W) : trial;
  end

  // Clamp is done in widened signed arithmetic so prev-MAX_STEP cannot wrap.
  always_comb begin
    candS  = GMIN_S + $signed({2'b00, rem_q});
    prevS  = $signed({3'b000, prev_q});
    loS    = prevS - STEP_S;
    if (loS < GMIN_S) loS = GMIN_S;
    hiS    = prevS + STEP_S;
    if (hiS > GMAX_S) hiS = GMAX_S;
    clampS = candS;
    if (candS < loS) clampS = loS;
    else if (candS > hiS) clampS = hiS;
    {unusedClampTop, gapY_d} = clampS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      gapY_q  <= MID;
      prev_q  <= MID;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            sr_q    <= rnd[15:0];
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= DIV;
          end
        end
        DIV: begin
          rem_q <= rem_d;
          sr_q  <= {sr_q[14:0], 1'b0};
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) state_q <= CLAMP;
        end
        CLAMP: begin
          gapY_q  <= gapY_d;
          valid_q <= 1'b1;
          state_q <= HOLD;
        end
        HOLD: begin
          if (ack) begin
            prev_q  <= gapY_q;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gap_y = gapY_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_pipe_gap_gen.sv
// Directed and randomized bench for pipe_gap_gen, checked against an
// arithmetic model of the modulo-and-clamp rule.
module tb_pipe_gap_gen;

  localparam int Y_W      = 10;
  localparam int GAP_MIN  = 80;
  localparam int GAP_MAX  = 360;
  localparam int MAX_STEP = 120;
  localparam int RANGE    = GAP_MAX - GAP_MIN + 1;
  localparam int MID      = (GAP_MIN + GAP_MAX) / 2;

  logic           clk;
  logic           rst_n;
  logic [31:0]    rnd;
  logic           req;
  logic           ack;
  logic [Y_W-1:0] gap_y;
  logic           valid;
  logic           busy;

  int total = 0;
  int bad   = 0;
  int prevModel = MID;

  pipe_gap_gen #(
    .Y_W(Y_W), .GAP_MIN(GAP_MIN), .GAP_MAX(GAP_MAX), .MAX_STEP(MAX_STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rnd(rnd), .req(req), .ack(ack),
    .gap_y(gap_y), .valid(valid), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int modelGap(input int r, input int p);
    int cand, lo, hi;
    cand = GAP_MIN + (r % RANGE);
    lo = (p - MAX_STEP > GAP_MIN) ? p - MAX_STEP : GAP_MIN;
    hi = (p + MAX_STEP < GAP_MAX) ? p + MAX_STEP : GAP_MAX;
    if (cand < lo) return lo;
    if (cand > hi) return hi;
    return cand;
  endfunction

  // One full request/ack transaction; assumes we sit 1 time unit after a rising edge in IDLE.
  task automatic applyStimulus(input logic [31:0] word, input int ackDelay, input bit noisy, input bit keepReq);
    int n;
    int expGap;
    expGap = modelGap(int'(word[15:0]), prevModel);
    req = 1'b1;
    rnd = word;
    @(posedge clk); #1;
    if (!keepReq) req = 1'b0;
    rnd = $urandom;
    checkOutput("busyAfterReq", {31'd0, busy}, 32'd1);
    checkOutput("validAfterReq", {31'd0, valid}, 32'd0);
    n = 0;
    while (valid !== 1'b1 && n < 40) begin
      if (noisy) begin
        req = keepReq | 1'($urandom_range(0, 1));
        ack = 1'($urandom_range(0, 1));
        rnd = $urandom;
      end
      @(posedge clk); #1;
      n++;
    end
    ack = 1'b0;
    checkOutput("latency", n, 17);
    checkOutput("gapY", {22'd0, gap_y}, expGap);
    checkOutput("busyInHold", {31'd0, busy}, 32'd1);
    for (int i = 0; i < ackDelay; i++) begin
      if (noisy) req = keepReq | 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      checkOutput("holdValid", {31'd0, valid}, 32'd1);
      checkOutput("holdGap", {22'd0, gap_y}, expGap);
    end
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    if (!keepReq) req = 1'b0;
    checkOutput("validAfterAck", {31'd0, valid}, 32'd0);
    checkOutput("busyAfterAck", {31'd0, busy}, 32'd0);
    prevModel = expGap;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rstValid", {31'd0, valid}, 32'd0);
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstGap", {22'd0, gap_y}, MID);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    prevModel = MID;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    ack   = 1'b0;
    rnd   = '0;
    @(posedge clk);
    @(posedge clk); #1;
    applyReset();

    applyStimulus(32'd983, 0, 1'b0, 1'b0);
    applyStimulus(32'h1234_FFFF, 2, 1'b0, 1'b0);

    // Abort a division part-way; the async reset must act before any clock edge.
    req = 1'b1;
    rnd = 32'd5000;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    applyReset();

    applyStimulus(32'd0, 1, 1'b0, 1'b0);
    applyReset();
    applyStimulus(32'd280, 0, 1'b0, 1'b0);
    applyStimulus(32'hABCD_0000, 0, 1'b0, 1'b0);

    applyStimulus(32'd12345, 50, 1'b1, 1'b0);

    applyStimulus(32'd40000, 3, 1'b0, 1'b1);
    applyStimulus(32'd777, 0, 1'b0, 1'b1);
    applyStimulus(32'd31337, 1, 1'b1, 1'b0);

    for (int k = 0; k < 1500; k++) begin
      applyStimulus($urandom, $urandom_range(0, 4), 1'b1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
